p3_serial_tx: RTL

- Serial frame transmitter. Takes a parallel word through a valid/ready handshake and drives it onto a 1-bit line: start bit, data bits LSB first, optional parity, then stop bit(s).
- Sits upstream of the team's serial-input FSMs and detectors and drives their x input.
- Gives benches and top levels a protocol-correct bit-stream source, instead of hand-written x waveforms.

---
 rtl/p3_tx_pkg.sv | 20 ++
 rtl/p3_bit_timer.sv | 38 +++
 rtl/p3_serial_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/p3_tx_pkg.sv
// Shared types and helpers for the p3 serial frame transmitter.
package p3_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam int   DW_MAX    = 16;

  // Even parity: the returned bit makes word plus parity carry an even count of ones.
  function automatic logic even_parity(input logic [DW_MAX-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/p3_bit_timer.sv
// Bit-period timer: tick marks the last cycle of each CLKS_PER_BIT-cycle bit period.
module p3_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, wrap at the end of the bit period.
  always_comb begin
    tick  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/p3_serial_tx.sv
// Serial frame transmitter: start bit, DW data bits LSB first, optional parity, stop bit(s).
// Parity bit is built only when P3_TX_PARITY_EN is defined.
module p3_serial_tx
  import p3_tx_pkg::*;
#(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          line,
  output logic          busy,
  output logic          done
);

  localparam int BCW = $clog2(DW + 2);

  tx_state_t      state_q, state_d;
  logic           line_q, line_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]  shift_q, shift_d;
  logic [DW-1:0]  shift_nxt;
  logic           tick;
  logic           timer_clear;
`ifdef P3_TX_PARITY_EN
  logic              parity_q, parity_d;
  logic [DW_MAX-1:0] parity_ext;
`endif

  assign in_ready    = (state_q == IDLE);
  assign timer_clear = (state_q == IDLE);
  assign line        = line_q;
  assign busy        = busy_q;
  assign done        = done_q;

  p3_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // Frame sequencing: next state, line level and counters.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    shift_nxt = shift_q >> 1;
`ifdef P3_TX_PARITY_EN
    parity_d   = parity_q;
    parity_ext = '0;
    parity_ext[DW-1:0] = in_data;
`endif
    case (state_q)
      IDLE: begin
        line_d    = LINE_IDLE;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        if (in_valid) begin
          // Start bit goes out on the accepting edge itself.
          shift_d = in_data;
          state_d = START;
          line_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef P3_TX_PARITY_EN
          parity_d = even_parity(parity_ext);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          line_d  = shift_q[0];
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == BCW'(DW - 1)) begin
            bit_cnt_d = '0;
`ifdef P3_TX_PARITY_EN
            state_d = PARITY;
            line_d  = parity_q;
`else
            state_d = STOP;
            line_d  = LINE_IDLE;
`endif
          end else begin
            shift_d   = shift_nxt;
            line_d    = shift_nxt[0];
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef P3_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          line_d  = LINE_IDLE;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d   = IDLE;
        line_d    = LINE_IDLE;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      line_q    <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef P3_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
`ifdef P3_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
